i2c_target_port: RTL and testbench

- I2C target (responder) for the open-drain scl/sda pins that the system's I2C controller drives.
- Decodes START, STOP and its own 7-bit address, then takes a register pointer byte.
- Bridges writes and reads to a byte-wide register interface in fabric, with an auto-incrementing pointer.
- Sits between the board I2C pins and user register logic, oversampling the bus on the system clock.

---
 rtl/i2c_target_port.sv | 232 +++++++++++++++++++++++
 tb/tb_i2c_target_port.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_port.sv
// I2C target bridging bus writes/reads to a byte-wide register port with an
// auto-incrementing pointer. Bus pins are oversampled on the system clock.
module i2c_target_port #(
  parameter logic [6:0]  TARGET_ADDR = 7'h42,
  parameter int unsigned PTR_W       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             scl_oe,
  output logic             sda_oe,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic [PTR_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             busy
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAckAddr, StPtr, StAckPtr, StWr, StAckWr, StRd, StRdAck, StWaitStop
  } state_e;

  localparam logic [PTR_W-1:0] PtrOne = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl, w_sda;
  logic                   w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]             w_shift_in;

  state_e           r_state, w_state;
  logic [3:0]       r_cnt, w_cnt;
  logic [7:0]       r_shift, w_shift;
  logic             r_sda_oe, w_sda_oe;
  logic [PTR_W-1:0] r_ptr, w_ptr;
  logic [PTR_W-1:0] r_rd_addr, w_rd_addr;
  logic             r_busy, w_busy;
  logic             r_rw, w_rw;
  logic             r_ack, w_ack;
  logic             r_wr_valid, w_wr_valid;
  logic [PTR_W-1:0] r_wr_addr, w_wr_addr;
  logic [7:0]       r_wr_data, w_wr_data;

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // SDA edges are qualified by the previous SCL level so a coincident SCL edge cannot mask them.
  assign w_start    = r_sda_d & ~w_sda & r_scl_d;
  assign w_stop     = ~r_sda_d & w_sda & r_scl_d;
  assign w_shift_in = {r_shift[6:0], w_sda};

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_sda_oe   <= 1'b0;
      r_ptr      <= '0;
      r_rd_addr  <= '0;
      r_busy     <= 1'b0;
      r_rw       <= 1'b0;
      r_ack      <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_shift    <= w_shift;
      r_sda_oe   <= w_sda_oe;
      r_ptr      <= w_ptr;
      r_rd_addr  <= w_rd_addr;
      r_busy     <= w_busy;
      r_rw       <= w_rw;
      r_ack      <= w_ack;
      r_wr_valid <= w_wr_valid;
      r_wr_addr  <= w_wr_addr;
      r_wr_data  <= w_wr_data;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_shift    = r_shift;
    w_sda_oe   = r_sda_oe;
    w_ptr      = r_ptr;
    w_rd_addr  = r_rd_addr;
    w_busy     = r_busy;
    w_rw       = r_rw;
    w_ack      = r_ack;
    w_wr_valid = 1'b0;
    w_wr_addr  = r_wr_addr;
    w_wr_data  = r_wr_data;

    if (w_start) begin
      w_state  = StAddr;
      w_cnt    = '0;
      w_sda_oe = 1'b0;
      w_busy   = 1'b0;
    end else if (w_stop) begin
      w_state  = StIdle;
      w_sda_oe = 1'b0;
      w_busy   = 1'b0;
    end else begin
      unique case (r_state)
        StAddr: begin
          if (w_scl_rise) begin
            w_shift = w_shift_in;
            w_cnt   = r_cnt + 4'd1;
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            if (r_shift[7:1] == TARGET_ADDR) begin
              w_state   = StAckAddr;
              w_sda_oe  = 1'b1;
              w_busy    = 1'b1;
              w_rw      = r_shift[0];
              w_rd_addr = r_ptr;
            end else begin
              w_state = StIdle;
            end
          end
        end
        StAckAddr: begin
          if (w_scl_fall) begin
            w_cnt = '0;
            if (r_rw) begin
              w_state  = StRd;
              w_shift  = rd_data;
              w_sda_oe = ~rd_data[7];
            end else begin
              w_state  = StPtr;
              w_sda_oe = 1'b0;
            end
          end
        end
        StPtr: begin
          if (w_scl_rise) begin
            w_shift = w_shift_in;
            w_cnt   = r_cnt + 4'd1;
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            w_ptr    = r_shift[PTR_W-1:0];
            w_sda_oe = 1'b1;
            w_state  = StAckPtr;
          end
        end
        StAckPtr: begin
          if (w_scl_fall) begin
            w_sda_oe = 1'b0;
            w_cnt    = '0;
            w_state  = StWr;
          end
        end
        StWr: begin
          if (w_scl_rise) begin
            w_shift = w_shift_in;
            w_cnt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_wr_valid = 1'b1;
              w_wr_addr  = r_ptr;
              w_wr_data  = w_shift_in;
            end
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            w_sda_oe = 1'b1;
            w_state  = StAckWr;
          end
        end
        StAckWr: begin
          if (w_scl_fall) begin
            w_sda_oe = 1'b0;
            w_ptr    = r_ptr + PtrOne;
            w_cnt    = '0;
            w_state  = StWr;
          end
        end
        StRd: begin
          if (w_scl_rise) begin
            w_cnt = r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_sda_oe = 1'b0;
              w_state  = StRdAck;
            end else if (r_cnt != 4'd0) begin
              w_sda_oe = ~r_shift[6];
              w_shift  = {r_shift[6:0], 1'b0};
            end
          end
        end
        StRdAck: begin
          // Advance the pointer on the ACK rise so rd_data is valid by the following fall.
          if (w_scl_rise) begin
            w_ack = ~w_sda;
            if (!w_sda) begin
              w_ptr     = r_ptr + PtrOne;
              w_rd_addr = r_ptr + PtrOne;
            end
          end else if (w_scl_fall) begin
            if (r_ack) begin
              w_shift  = rd_data;
              w_sda_oe = ~rd_data[7];
              w_cnt    = '0;
              w_state  = StRd;
            end else begin
              w_state = StWaitStop;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign scl_oe   = 1'b0;
  assign sda_oe   = r_sda_oe;
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign rd_addr  = r_rd_addr;
  assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_target_port.sv
// Scoreboard bench: a bus-level controller model drives frames, expectations are queued
// from a pointer/register model and checked by independent write and bus monitors.
module tb_i2c_target_port;

  localparam int HALF = 8;

  typedef struct packed {logic [3:0] a; logic [7:0] d;} wr_exp_t;
  typedef struct packed {logic [3:0] nb; logic [7:0] v;} bus_exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       ctrl_scl, ctrl_sda;
  logic       scl_oe, sda_oe, wr_valid, busy;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;
  logic       scl_line, sda_line;

  int n_checks = 0;
  int n_pass   = 0;
  int m_ptr    = 0;
  int skew     = 2;
  int quiet_hits = 0;
  logic listen = 1'b0;
  logic quiet  = 1'b0;
  logic [7:0] wdat[$];
  wr_exp_t  exp_wr[$];
  bus_exp_t exp_bus[$];
  logic [7:0] mb_sh = 8'h00;
  int mb_nb = 0;

  assign scl_line = ctrl_scl & ~scl_oe;
  assign sda_line = ctrl_sda & ~sda_oe;
  assign rd_data  = {rd_addr, rd_addr};

  always #5 clk = ~clk;

  i2c_target_port #(.TARGET_ADDR(7'h42), .PTR_W(4), .SYNC_STAGES(2)) dut (
    .clk_clk(clk), .reset_reset(reset), .scl_in(scl_line), .sda_in(sda_line),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_bus(input logic [3:0] nb, input logic [7:0] v);
    bus_exp_t e;
    e.nb = nb;
    e.v  = v;
    exp_bus.push_back(e);
  endtask

  task automatic bit_cycle(input logic b);
    wait_clk(skew);
    ctrl_sda = b;
    wait_clk(HALF - skew);
    ctrl_scl = 1'b1;
    wait_clk(HALF);
    ctrl_scl = 1'b0;
  endtask

  task automatic do_start();
    wait_clk(2);
    ctrl_sda = 1'b1;
    wait_clk(HALF);
    ctrl_scl = 1'b1;
    wait_clk(HALF);
    ctrl_sda = 1'b0;
    wait_clk(HALF);
    ctrl_scl = 1'b0;
  endtask

  task automatic do_stop();
    wait_clk(2);
    ctrl_sda = 1'b0;
    wait_clk(HALF);
    ctrl_scl = 1'b1;
    wait_clk(HALF);
    ctrl_sda = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bit_cycle(b[i]);
    listen = 1'b1;
    bit_cycle(1'b1);
    listen = 1'b0;
  endtask

  task automatic recv_byte(input logic ack_bit);
    listen = 1'b1;
    repeat (8) bit_cycle(1'b1);
    listen = 1'b0;
    bit_cycle(ack_bit);
  endtask

  // Controller write frame; the model predicts ACK/NACK slots and register writes.
  task automatic write_txn(input logic [6:0] a, input logic [7:0] p, input logic stop);
    logic match;
    wr_exp_t e;
    match = (a == 7'h42);
    do_start();
    push_bus(4'd1, {7'd0, ~match});
    send_byte({a, 1'b0});
    check("busy_after_addr", busy, match);
    push_bus(4'd1, {7'd0, ~match});
    if (match) m_ptr = p % 16;
    send_byte(p);
    foreach (wdat[i]) begin
      if (match) begin
        e.a = 4'(m_ptr);
        e.d = wdat[i];
        exp_wr.push_back(e);
        m_ptr = (m_ptr + 1) % 16;
      end
      push_bus(4'd1, {7'd0, ~match});
      send_byte(wdat[i]);
    end
    if (stop) begin
      do_stop();
      wait_clk(4);
      check("busy_after_stop", busy, 1'b0);
    end
  endtask

  // Read n bytes from the current pointer: ACK all but the last, NACK the last.
  task automatic read_part(input int n);
    do_start();
    push_bus(4'd1, 8'd0);
    send_byte(8'h85);
    check("busy_rd", busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      push_bus(4'd8, 8'((m_ptr * 17) % 256));
      if (i == n - 1) begin
        recv_byte(1'b1);
        wait_clk(4);
        check("released_after_nack", sda_oe, 1'b0);
      end else begin
        recv_byte(1'b0);
        m_ptr = (m_ptr + 1) % 16;
      end
    end
    do_stop();
    wait_clk(4);
    check("busy_after_rd_stop", busy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!reset && wr_valid) begin
      if (exp_wr.size() == 0) begin
        fail("wr_unexpected");
      end else begin
        check("wr_addr", wr_addr, exp_wr[0].a);
        check("wr_data", wr_data, exp_wr[0].d);
        void'(exp_wr.pop_front());
      end
    end
    if (quiet && sda_oe) quiet_hits++;
  end

  // Samples the line mid-high on every bit the controller leaves released.
  always @(posedge ctrl_scl) begin
    if (listen) begin
      repeat (HALF / 2) @(negedge clk);
      mb_sh = {mb_sh[6:0], sda_line};
      mb_nb++;
      if (exp_bus.size() == 0) begin
        fail("bus_unexpected");
        mb_nb = 0;
        mb_sh = 8'h00;
      end else if (mb_nb == int'(exp_bus[0].nb)) begin
        check(exp_bus[0].nb == 4'd1 ? "ack_slot" : "rd_byte", mb_sh, exp_bus[0].v);
        void'(exp_bus.pop_front());
        mb_nb = 0;
        mb_sh = 8'h00;
      end
    end
  end

  initial begin
    #20000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] a;
    int k;
    reset = 1'b1;
    ctrl_scl = 1'b1;
    ctrl_sda = 1'b1;
    wait_clk(5);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_rd_addr", rd_addr, 4'h0);
    check("rst_scl_oe", scl_oe, 1'b0);
    reset = 1'b0;
    wait_clk(5);

    wdat = '{8'hA5, 8'h5A};
    write_txn(7'h42, 8'h03, 1'b1);

    quiet = 1'b1;
    wdat = '{8'h11, 8'h22};
    write_txn(7'h43, 8'h09, 1'b1);
    quiet = 1'b0;
    check("mismatch_quiet", quiet_hits, 0);
    wdat = '{8'($urandom)};
    write_txn(7'h42, 8'($urandom), 1'b1);

    wdat = {};
    write_txn(7'h42, 8'h0E, 1'b0);
    read_part(3);

    write_txn(7'h42, 8'h07, 1'b0);
    repeat (4) bit_cycle(1'($urandom));
    do_stop();
    wait_clk(4);
    check("busy_early_stop", busy, 1'b0);
    read_part(1);

    write_txn(7'h42, 8'h01, 1'b0);
    do_start();
    push_bus(4'd1, 8'd0);
    send_byte(8'h85);
    bit_cycle(1'b1);
    k = 0;
    while (k < 40 && !sda_oe) begin
      wait_clk(1);
      k++;
    end
    check("oe_before_reset", sda_oe, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_sda_oe", sda_oe, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_rd_addr", rd_addr, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;
    do_stop();
    wait_clk(4);
    read_part(1);

    skew = 1;
    wdat = '{8'hC3};
    write_txn(7'h42, 8'h0B, 1'b1);
    skew = 2;

    for (int it = 0; it < 8; it++) begin
      a = ($urandom_range(0, 4) == 0) ? (7'h42 ^ 7'($urandom_range(1, 127))) : 7'h42;
      wdat = {};
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) wdat.push_back(8'($urandom));
      if (a == 7'h42 && $urandom_range(0, 1) == 1) begin
        write_txn(a, 8'($urandom), 1'b0);
        read_part(int'($urandom_range(1, 3)));
      end else begin
        write_txn(a, 8'($urandom), 1'b1);
      end
    end

    wait_clk(20);
    check("wr_queue_drained", exp_wr.size(), 0);
    check("bus_queue_drained", exp_bus.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
